// File: rtl/i2c_sub_regfile_if.sv
// Host-side register-file port: combinational read, host writes, and the I2C write-notification strobe.
interface i2c_sub_regfile_if #(
  parameter int PW = 4
);
  logic          host_we;
  logic [PW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic [7:0]    host_rdata;
  logic          wr_strobe;
  logic [PW-1:0] wr_addr;
  logic [7:0]    wr_data;

  modport master (
    output host_we, host_addr, host_wdata,
    input  host_rdata, wr_strobe, wr_addr, wr_data
  );

  modport slave (
    input  host_we, host_addr, host_wdata,
    output host_rdata, wr_strobe, wr_addr, wr_data
  );
endinterface

// File: rtl/i2c_sub_regfile.sv
// I2C subordinate exposing a DEPTH-byte register file with an auto-incrementing pointer,
// oversampled on clk_400; the host port loses to an I2C write to the same byte in the same cycle.
module i2c_sub_regfile #(
  parameter logic [6:0] MY_ADDR = 7'h01,
  parameter int         DEPTH   = 16,
  localparam int        PW      = $clog2(DEPTH)
) (
  input  logic            clk_400,
  input  logic            rst_n,
  input  logic            SCL,
  inout  wire             SDA,
  i2c_sub_regfile_if.slave host,
  output logic            busy,
  output logic            ack_error
);

  typedef enum logic [3:0] {
    IDLE, ADDR_RX, ADDR_ACK, PTR_RX, PTR_ACK, DATA_RX, DATA_ACK, DATA_TX, MACK, WAIT_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    scl_q, scl_d, sda_q, sda_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          ack_error_q, ack_error_d;
  logic          acked_q, acked_d;
  logic          nack_q, nack_d;
  logic          nack_clk_q, nack_clk_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [PW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];

  logic          scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, i2c_we;
  logic [7:0]    byte_in;
  logic [PW-1:0] ptr_inc;

  assign scl_s     = scl_q[1];
  assign sda_s     = sda_q[1];
  assign scl_rise  = scl_s & ~scl_q[2];
  assign scl_fall  = ~scl_s & scl_q[2];
  assign start_det = scl_s & sda_q[2] & ~sda_s & ~sda_oe_q;
  assign stop_det  = scl_s & ~sda_q[2] & sda_s & ~sda_oe_q;
  assign byte_in   = {shift_q[6:0], sda_s};
  assign ptr_inc   = ptr_q + PW'(1);

  always_comb begin
    scl_d       = {scl_q[1:0], SCL};
    sda_d       = {sda_q[1:0], SDA};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    ack_error_d = ack_error_q;
    acked_d     = acked_q;
    nack_d      = nack_q;
    nack_clk_d  = nack_clk_q;
    i2c_we      = 1'b0;
    if (start_det) begin
      state_d     = ADDR_RX;
      bit_cnt_d   = 3'd7;
      busy_d      = 1'b1;
      ack_error_d = 1'b0;
      sda_oe_d    = 1'b0;
      acked_d     = 1'b0;
      nack_d      = 1'b0;
      nack_clk_d  = 1'b0;
    end else if (stop_det) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      sda_oe_d   = 1'b0;
      acked_d    = 1'b0;
      nack_d     = 1'b0;
      nack_clk_d = 1'b0;
    end else begin
      case (state_q)
        ADDR_RX, PTR_RX, DATA_RX: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) begin
              case (state_q)
                ADDR_RX: state_d = ADDR_ACK;
                PTR_RX: begin
                  state_d = PTR_ACK;
                  ptr_d   = byte_in[PW-1:0];
                end
                default: begin
                  state_d = DATA_ACK;
                  i2c_we  = 1'b1;
                end
              endcase
            end
          end
        end
        // The ACK slot is bounded by two SCL falls: first fall drives, second releases.
        ADDR_ACK: begin
          if (shift_q[7:1] != MY_ADDR) begin
            state_d = WAIT_STOP;
            busy_d  = 1'b0;
          end else if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (shift_q[0]) begin
              state_d   = DATA_TX;
              shift_d   = mem_q[ptr_q];
              sda_oe_d  = ~mem_q[ptr_q][7];
              bit_cnt_d = 3'd7;
            end else begin
              state_d   = PTR_RX;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd7;
            end
          end
        end
        PTR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d = ~sda_oe_q;
            if (sda_oe_q) begin
              state_d   = DATA_RX;
              bit_cnt_d = 3'd7;
              if (state_q == DATA_ACK) ptr_d = ptr_inc;
            end
          end
        end
        DATA_TX: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin
              sda_oe_d = 1'b0;
              state_d  = MACK;
              acked_d  = 1'b0;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q - 3'd1;
            end
          end
        end
        MACK: begin
          if (!acked_q && scl_rise) begin
            ptr_d = ptr_inc;
            if (sda_s) begin
              state_d = WAIT_STOP;
              nack_d  = 1'b1;
            end else begin
              acked_d = 1'b1;
            end
          end else if (acked_q && scl_fall) begin
            acked_d   = 1'b0;
            state_d   = DATA_TX;
            shift_d   = mem_q[ptr_q];
            sda_oe_d  = ~mem_q[ptr_q][7];
            bit_cnt_d = 3'd7;
          end
        end
        // Every STOP/Sr is preceded by an SCL rise, so only a rise followed by a fall
        // (a complete extra bit) after a NACK counts as the master ignoring it.
        WAIT_STOP: begin
          sda_oe_d = 1'b0;
          if (nack_q && scl_rise) nack_clk_d = 1'b1;
          if (nack_clk_q && scl_fall) begin
            ack_error_d = 1'b1;
            nack_d      = 1'b0;
            nack_clk_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (host.host_we) mem_d[host.host_addr] = host.host_wdata;
    if (i2c_we) mem_d[ptr_q] = byte_in;
    wr_strobe_d = i2c_we;
    wr_addr_d   = i2c_we ? ptr_q : wr_addr_q;
    wr_data_d   = i2c_we ? byte_in : wr_data_q;
  end

  always_ff @(posedge clk_400 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      scl_q       <= 3'b111;
      sda_q       <= 3'b111;
      bit_cnt_q   <= 3'd7;
      shift_q     <= 8'h00;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      ack_error_q <= 1'b0;
      acked_q     <= 1'b0;
      nack_q      <= 1'b0;
      nack_clk_q  <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
      mem_q       <= '{default: 8'h00};
    end else begin
      state_q     <= state_d;
      scl_q       <= scl_d;
      sda_q       <= sda_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      ack_error_q <= ack_error_d;
      acked_q     <= acked_d;
      nack_q      <= nack_d;
      nack_clk_q  <= nack_clk_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      mem_q       <= mem_d;
    end
  end

  assign SDA             = sda_oe_q ? 1'b0 : 1'bz;
  assign host.host_rdata = mem_q[host.host_addr];
  assign host.wr_strobe  = wr_strobe_q;
  assign host.wr_addr    = wr_addr_q;
  assign host.wr_data    = wr_data_q;
  assign busy            = busy_q;
  assign ack_error       = ack_error_q;

endmodule

// File: tb/tb_i2c_sub_regfile.sv
// Bench for i2c_sub_regfile: bit-banged I2C master plus an array/queue model of the register file.
`timescale 1ns/1ps
module tb_i2c_sub_regfile;
  localparam int DEPTH = 16;
  localparam int PW    = 4;
  localparam int Q     = 8;

  logic clk_400  = 1'b0;
  logic rst_n    = 1'b0;
  logic m_scl    = 1'b1;
  logic m_sda_oe = 1'b0;
  wire  sda;
  logic busy, ack_error;

  always #5 clk_400 = ~clk_400;
  pullup (sda);
  assign sda = m_sda_oe ? 1'b0 : 1'bz;

  i2c_sub_regfile_if #(.PW(PW)) ifc ();

  i2c_sub_regfile #(.MY_ADDR(7'h01), .DEPTH(DEPTH)) dut (
    .clk_400  (clk_400),
    .rst_n    (rst_n),
    .SCL      (m_scl),
    .SDA      (sda),
    .host     (ifc),
    .busy     (busy),
    .ack_error(ack_error)
  );

  logic [7:0]  mem_m [DEPTH];
  int          ptr_m;
  logic [11:0] exp_strb [$];
  logic [7:0]  dq [$];
  logic [11:0] got_strb [4096];
  int          n_strb = 0;
  int          strb_rd = 0;
  int          drv_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  // Captures strobe pulses and counts cycles where the DUT pulls SDA low.
  always @(negedge clk_400) begin
    if (ifc.wr_strobe && n_strb < 4096) begin
      got_strb[n_strb] = {ifc.wr_addr, ifc.wr_data};
      n_strb++;
    end
    if (!m_sda_oe && sda === 1'b0) drv_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  task automatic qw(input int n);
    repeat (n) @(negedge clk_400);
  endtask

  task automatic i2c_start();
    m_sda_oe = 1'b0; qw(Q);
    m_scl = 1'b1;    qw(2*Q);
    m_sda_oe = 1'b1; qw(2*Q);
    m_scl = 1'b0;    qw(Q);
  endtask

  task automatic i2c_stop();
    m_sda_oe = 1'b1; qw(Q);
    m_scl = 1'b1;    qw(2*Q);
    m_sda_oe = 1'b0; qw(2*Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda_oe = ~b; qw(Q);
    m_scl = 1'b1;  qw(2*Q);
    m_scl = 1'b0;  qw(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda_oe = 1'b0; qw(Q);
    m_scl = 1'b1;    qw(Q);
    b = sda;         qw(Q);
    m_scl = 1'b0;    qw(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic rd_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  task automatic chk_strb();
    chk("strb_cnt", n_strb - strb_rd, exp_strb.size());
    foreach (exp_strb[i]) begin
      if (strb_rd < n_strb) begin
        chk("strb", got_strb[strb_rd], exp_strb[i]);
        strb_rd++;
      end
    end
    exp_strb.delete();
    strb_rd = n_strb;
  endtask

  task automatic host_wr(input int a, input logic [7:0] d);
    @(negedge clk_400);
    ifc.host_we = 1'b1; ifc.host_addr = PW'(a); ifc.host_wdata = d;
    @(negedge clk_400);
    ifc.host_we = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic host_chk(input int a, input string tag);
    @(negedge clk_400);
    ifc.host_addr = PW'(a);
    #1;
    chk(tag, ifc.host_rdata, mem_m[a]);
  endtask

  // Pointer write followed by the bytes queued in dq.
  task automatic do_write(input logic [7:0] p);
    logic ack;
    i2c_start();
    wr_byte(8'h02, ack); chk("w_addr_ack", ack, 0);
    chk("w_busy", busy, 1);
    wr_byte(p, ack);     chk("w_ptr_ack", ack, 0);
    ptr_m = p % DEPTH;
    foreach (dq[i]) begin
      wr_byte(dq[i], ack); chk("w_data_ack", ack, 0);
      mem_m[ptr_m] = dq[i];
      exp_strb.push_back({PW'(ptr_m), dq[i]});
      ptr_m = (ptr_m + 1) % DEPTH;
    end
    i2c_stop();
    chk("w_busy_end", busy, 0);
    chk_strb();
  endtask

  task automatic do_read(input bit set_ptr, input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] d;
    i2c_start();
    if (set_ptr) begin
      wr_byte(8'h02, ack); chk("r_waddr_ack", ack, 0);
      wr_byte(p, ack);     chk("r_ptr_ack", ack, 0);
      ptr_m = p % DEPTH;
      i2c_start();
    end
    wr_byte(8'h03, ack); chk("r_addr_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      rd_byte(d, (i == n - 1));
      chk("rd_byte", d, mem_m[ptr_m]);
      ptr_m = (ptr_m + 1) % DEPTH;
    end
    i2c_stop();
    chk("r_ack_error", ack_error, 0);
  endtask

  // Host keeps writing ha/hd every cycle until the I2C write of id to p is strobed.
  task automatic coll(input int ha, input logic [7:0] hd, input logic [7:0] p, input logic [7:0] id);
    logic ack;
    i2c_start();
    wr_byte(8'h02, ack); chk("c_addr_ack", ack, 0);
    wr_byte(p, ack);     chk("c_ptr_ack", ack, 0);
    ptr_m = p % DEPTH;
    @(negedge clk_400);
    ifc.host_we = 1'b1; ifc.host_addr = PW'(ha); ifc.host_wdata = hd;
    fork
      wr_byte(id, ack);
      begin
        for (int i = 0; i < 400; i++) begin
          @(negedge clk_400);
          if (ifc.wr_strobe) break;
        end
        ifc.host_we = 1'b0;
      end
    join
    chk("c_data_ack", ack, 0);
    mem_m[ha] = hd;
    mem_m[ptr_m] = id;
    exp_strb.push_back({PW'(ptr_m), id});
    ptr_m = (ptr_m + 1) % DEPTH;
    i2c_stop();
    chk_strb();
  endtask

  initial begin
    logic ack;
    logic [7:0] d;
    int d0, s0;
    ifc.host_we = 1'b0; ifc.host_addr = '0; ifc.host_wdata = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
    ptr_m = 0;

    qw(5);
    chk("rst_busy", busy, 0);
    chk("rst_ack_error", ack_error, 0);
    chk("rst_strobe", ifc.wr_strobe, 0);
    chk("rst_wr_addr", ifc.wr_addr, 0);
    chk("rst_wr_data", ifc.wr_data, 0);
    chk("rst_sda", sda, 1);
    host_chk(0, "rst_mem0");
    host_chk(DEPTH - 1, "rst_mem15");
    rst_n = 1'b1;
    qw(5);

    // Write burst, then confirm pointer landed on 7.
    dq = '{8'hA1, 8'hB2};
    do_write(8'h05);
    host_chk(5, "burst_mem5");
    host_chk(6, "burst_mem6");
    host_wr(7, 8'($urandom));
    do_read(0, 8'h00, 1);

    // Combined read with repeated START; pointer should be 5 afterwards.
    host_wr(3, 8'h3C);
    host_wr(4, 8'h4D);
    do_read(1, 8'h03, 2);
    host_wr(5, 8'($urandom));
    do_read(0, 8'h00, 1);

    // Pointer wrap for writes and reads.
    dq = '{8'h11, 8'h22};
    do_write(8'h0F);
    host_chk(15, "wrap_mem15");
    host_chk(0, "wrap_mem0");
    host_wr(1, 8'($urandom));
    do_read(0, 8'h00, 1);
    do_read(1, 8'h0F, 2);

    // Address mismatch: nothing driven, nothing written.
    d0 = drv_cnt; s0 = n_strb;
    i2c_start();
    wr_byte(8'h08, ack); chk("mm_addr_nack", ack, 1);
    chk("mm_busy", busy, 0);
    wr_byte(8'hFF, ack); chk("mm_data_nack", ack, 1);
    i2c_stop();
    chk("mm_sda_driven", drv_cnt - d0, 0);
    chk("mm_strobes", n_strb - s0, 0);
    do_read(0, 8'h00, 1);

    // NACK followed by an extra master clock sets ack_error until the next START.
    i2c_start();
    wr_byte(8'h03, ack); chk("ae_addr_ack", ack, 0);
    rd_byte(d, 1'b1);
    chk("ae_byte", d, mem_m[ptr_m]);
    ptr_m = (ptr_m + 1) % DEPTH;
    chk("ae_before", ack_error, 0);
    send_bit(1'b1);
    chk("ae_set", ack_error, 1);
    i2c_stop();
    chk("ae_sticky", ack_error, 1);
    i2c_start();
    chk("ae_cleared", ack_error, 0);
    i2c_stop();

    // Collisions: same address (I2C wins) and different addresses (both land).
    coll(5, 8'h77, 8'h05, 8'h99);
    host_chk(5, "coll_same");
    coll(12, 8'h5A, 8'h06, 8'h66);
    host_chk(12, "coll_host");
    host_chk(6, "coll_i2c");

    // Reset in the middle of a read byte.
    host_wr(9, 8'h00);
    i2c_start();
    wr_byte(8'h02, ack); chk("rr_waddr_ack", ack, 0);
    wr_byte(8'h09, ack); chk("rr_ptr_ack", ack, 0);
    i2c_start();
    wr_byte(8'h03, ack); chk("rr_addr_ack", ack, 0);
    for (int i = 0; i < 3; i++) recv_bit(ack);
    m_sda_oe = 1'b0;
    qw(Q);
    chk("rr_sda_driven", sda, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_sda_released", sda, 1);
    chk("rr_busy", busy, 0);
    chk("rr_ack_error", ack_error, 0);
    chk("rr_strobe", ifc.wr_strobe, 0);
    chk("rr_wr_addr", ifc.wr_addr, 0);
    chk("rr_wr_data", ifc.wr_data, 0);
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
    ptr_m = 0;
    for (int i = 0; i < DEPTH; i++) host_chk(i, "rr_mem");
    m_scl = 1'b1;
    qw(4);
    rst_n = 1'b1;
    qw(4);
    strb_rd = n_strb;
    dq = '{8'($urandom), 8'($urandom)};
    do_write(8'h02);
    host_chk(2, "rr_post_mem2");
    host_chk(3, "rr_post_mem3");

    // Randomised traffic against the model.
    for (int it = 0; it < 10; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          dq.delete();
          repeat ($urandom_range(1, 4)) dq.push_back(8'($urandom));
          do_write(8'($urandom));
        end
        1: do_read(1, 8'($urandom), $urandom_range(1, 3));
        default: begin
          host_wr($urandom_range(0, DEPTH - 1), 8'($urandom));
          do_read(0, 8'h00, $urandom_range(1, 3));
        end
      endcase
    end
    for (int i = 0; i < DEPTH; i++) host_chk(i, "final_mem");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
